// File: rtl/sid_pkg.sv
// -----------------------------------------------------------------------------
// sid_pkg
// Shared constants for the SID PWM output DAC stage.
//   SID_PWM_IN_W  : width of the signed audio sample feeding the DAC
//   SID_PWM_W     : PWM resolution; one PWM period is 2^SID_PWM_W clocks
//   SID_PWM_ERR_W : width of the noise-shaping error residue
//   SID_PWM_MID   : midscale duty, i.e. the duty that represents silence
// -----------------------------------------------------------------------------
package sid_pkg;

   localparam int SID_PWM_IN_W  = 12;
   localparam int SID_PWM_W     = 8;
   localparam int SID_PWM_ERR_W = SID_PWM_IN_W - SID_PWM_W;

   localparam logic [SID_PWM_W-1:0] SID_PWM_MID = {1'b1, {(SID_PWM_W-1){1'b0}}};

endpackage

// File: rtl/sid_pwm_shaper.sv
// -----------------------------------------------------------------------------
// sid_pwm_shaper
// Combinational first-order error-feedback quantiser. Converts a signed sample
// to offset binary, adds the residue left over from the previous period, and
// splits the sum into a PWM duty (upper bits) and a new residue (lower bits).
// Ports:
//   active    : signed sample currently being reproduced (IN_W bits)
//   err       : residue carried from the previous period (IN_W-PWM_W bits)
//   duty_next : duty for the coming period (PWM_W bits)
//   err_next  : residue to carry into the following period
// -----------------------------------------------------------------------------
module sid_pwm_shaper
   import sid_pkg::*;
#(
   parameter int IN_W  = SID_PWM_IN_W,
   parameter int PWM_W = SID_PWM_W
) (
   input  logic [IN_W-1:0]       active,
   input  logic [IN_W-PWM_W-1:0] err,
   output logic [PWM_W-1:0]      duty_next,
   output logic [IN_W-PWM_W-1:0] err_next
);

   localparam int ERR_W = IN_W - PWM_W;

   logic [IN_W-1:0] offset_sample;
   logic [IN_W:0]   sum;

   // Inverting the sign bit maps two's complement onto offset binary so that
   // the most negative sample gives duty 0. A carry out of the sum means the
   // residue pushed a near-full-scale sample past the top; clamp to full duty
   // and drop the residue rather than wrapping to a near-zero duty.
   always_comb begin
      offset_sample = {~active[IN_W-1], active[IN_W-2:0]};
      sum           = {1'b0, offset_sample} + {{(PWM_W+1){1'b0}}, err};
      if (sum[IN_W]) begin
         duty_next = '1;
         err_next  = '0;
      end else begin
         duty_next = sum[IN_W-1 -: PWM_W];
         err_next  = sum[ERR_W-1:0];
      end
   end

endmodule

// File: rtl/sid_pwm_dac.sv
// -----------------------------------------------------------------------------
// sid_pwm_dac
// Single-bit PWM output stage with first-order noise shaping. A one-entry
// holding register accepts samples at any time; at each period boundary the
// held sample (or, on underrun, the previous one) is re-quantised together
// with the carried error to give the next period's duty.
// Ports:
//   clk, rst_n    : clock and asynchronous active-low reset
//   ena           : run enable; low freezes the counter and forces pwm_out low
//   sample_in     : signed audio sample, valid with sample_valid
//   sample_valid  : producer offers sample_in this cycle
//   sample_ready  : holding register empty; transfer on valid && ready
//   pwm_out       : registered pin drive, high pulse left-aligned at cnt==0
//   period_tick   : one-cycle pulse aligned with the first cycle of a period
//   underrun      : sticky, a boundary passed with no held sample
//   underrun_clr  : synchronous clear of underrun (a set in the same cycle wins)
// -----------------------------------------------------------------------------
module sid_pwm_dac
   import sid_pkg::*;
#(
   parameter int IN_W  = SID_PWM_IN_W,
   parameter int PWM_W = SID_PWM_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   input  logic [IN_W-1:0] sample_in,
   input  logic            sample_valid,
   output logic            sample_ready,
   output logic            pwm_out,
   output logic            period_tick,
   output logic            underrun,
   input  logic            underrun_clr
);

   localparam int ERR_W = IN_W - PWM_W;
   localparam logic [PWM_W-1:0] DUTY_MID = {1'b1, {(PWM_W-1){1'b0}}};

   logic [PWM_W-1:0] cnt;
   logic [PWM_W-1:0] duty;
   logic [ERR_W-1:0] err;
   logic [IN_W-1:0]  hold;
   logic             hold_full;
   logic [IN_W-1:0]  active;

   logic             boundary;
   logic [IN_W-1:0]  active_sel;
   logic [PWM_W-1:0] duty_next;
   logic [ERR_W-1:0] err_next;

   // The last count of an enabled period is where the next period's sample
   // and duty are chosen; the shaper sees the sample that will actually play.
   assign boundary     = ena && (cnt == '1);
   assign active_sel   = (boundary && hold_full) ? hold : active;
   assign sample_ready = !hold_full;

   sid_pwm_shaper #(
      .IN_W  (IN_W),
      .PWM_W (PWM_W)
   ) u_shaper (
      .active    (active_sel),
      .err       (err),
      .duty_next (duty_next),
      .err_next  (err_next)
   );

   // Period counter plus the per-period sample, duty and residue. All of them
   // hold while ena is low so a paused period resumes exactly where it left.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         duty   <= DUTY_MID;
         err    <= '0;
         active <= '0;
      end else begin
         if (ena) begin
            cnt <= cnt + 1'b1;
         end
         if (boundary) begin
            active <= active_sel;
            duty   <= duty_next;
            err    <= err_next;
         end
      end
   end

   // One-entry holding register. Draining at a boundary and accepting a new
   // sample are mutually exclusive because acceptance needs the entry empty,
   // so a sample offered during the boundary cycle lands one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold      <= '0;
         hold_full <= 1'b0;
      end else begin
         if (boundary && hold_full) begin
            hold_full <= 1'b0;
         end else if (sample_valid && !hold_full) begin
            hold      <= sample_in;
            hold_full <= 1'b1;
         end
      end
   end

   // Sticky underrun flag; a new underrun takes priority over a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun <= 1'b0;
      end else if (boundary && !hold_full) begin
         underrun <= 1'b1;
      end else if (underrun_clr) begin
         underrun <= 1'b0;
      end
   end

   // Registered pin drive and period marker. Since cnt < duty can never hold
   // for every count, full duty still leaves one low cycle per period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_out     <= 1'b0;
         period_tick <= 1'b0;
      end else begin
         pwm_out     <= ena && (cnt < duty);
         period_tick <= ena && (cnt == '0);
      end
   end

endmodule

// File: tb/tb_sid_pwm_dac.sv
// -----------------------------------------------------------------------------
// tb_sid_pwm_dac
// Self-checking bench for sid_pwm_dac. A period-level integer model of the
// DAC predicts every output each cycle; directed scenarios add hand-derived
// literal expectations (high counts per period, flag values).
// -----------------------------------------------------------------------------
module tb_sid_pwm_dac;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic [11:0] sample_in;
   logic        sample_valid;
   logic        sample_ready;
   logic        pwm_out;
   logic        period_tick;
   logic        underrun;
   logic        underrun_clr;

   int compared   = 0;
   int mismatched = 0;

   // Behavioural model state (plain integers).
   int m_cnt, m_duty, m_err, m_hold, m_active;
   bit m_hf, m_under, m_pwm, m_tick;

   always #5 clk = ~clk;

   sid_pwm_dac dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .pwm_out      (pwm_out),
      .period_tick  (period_tick),
      .underrun     (underrun),
      .underrun_clr (underrun_clr)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Quantiser rule in arithmetic form: offset = sample + 2048, add residue,
   // duty is the sum divided by 16, residue the remainder, clamp on overflow.
   function automatic void shape(input int smp, input int e, output int d, output int ne);
      int s;
      s = smp + 2048 + e;
      if (s >= 4096) begin
         d  = 255;
         ne = 0;
      end else begin
         d  = s / 16;
         ne = s % 16;
      end
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_duty = 128; m_err = 0; m_hold = 0; m_active = 0;
      m_hf = 0; m_under = 0; m_pwm = 0; m_tick = 0;
   endtask

   task automatic model_step();
      bit bnd, hf_old, acc;
      int d, e;
      bnd    = ena && (m_cnt == 255);
      hf_old = m_hf;
      acc    = sample_valid && !hf_old;
      m_pwm  = ena && (m_cnt < m_duty);
      m_tick = ena && (m_cnt == 0);
      if (bnd) begin
         if (hf_old) begin
            m_active = m_hold;
            m_hf     = 0;
         end
         shape(m_active, m_err, d, e);
         m_duty = d;
         m_err  = e;
      end
      if (bnd && !hf_old) m_under = 1;
      else if (underrun_clr) m_under = 0;
      if (acc) begin
         m_hold = int'($signed(sample_in));
         m_hf   = 1;
      end
      if (ena) m_cnt = (m_cnt + 1) % 256;
   endtask

   // Model process: reset asynchronously, otherwise advance one clock.
   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // Compare process: every falling edge, all outputs against the model.
   initial begin
      forever begin
         @(negedge clk);
         checkOutput("pwm_out", pwm_out, m_pwm);
         checkOutput("period_tick", period_tick, m_tick);
         checkOutput("underrun", underrun, m_under);
         checkOutput("sample_ready", sample_ready, !m_hf);
      end
   end

   task automatic applyStimulus(input logic [11:0] smp);
      int n = 0;
      @(negedge clk);
      while (!sample_ready && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (!sample_ready) checkOutput("ready_timeout", 0, 1);
      sample_in    = smp;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic wait_tick();
      int n = 0;
      while (!period_tick && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (!period_tick) checkOutput("tick_timeout", 0, 1);
   endtask

   task automatic wait_model_cnt(input int target);
      int n = 0;
      while (m_cnt != target && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (m_cnt != target) checkOutput("cnt_timeout", 0, 1);
   endtask

   // Counts high cycles from one period_tick up to (not including) the next.
   task automatic measure_period(output int highs, output int len);
      wait_tick();
      highs = 0;
      len   = 0;
      do begin
         highs += int'(pwm_out);
         len++;
         @(negedge clk);
      end while (!period_tick && len < 1000);
      if (!period_tick) checkOutput("period_timeout", 0, 1);
   endtask

   initial begin
      int highs, len, h0, h1, h2, h3, d, e;

      rst_n        = 1'b1;
      ena          = 1'b0;
      sample_in    = '0;
      sample_valid = 1'b0;
      underrun_clr = 1'b0;
      #1 rst_n = 1'b0;

      // Pin the model's quantiser against hand-worked values.
      shape(2047, 0, d, e);  checkOutput("shape_7ff_duty", d, 255); checkOutput("shape_7ff_err", e, 15);
      shape(2047, 15, d, e); checkOutput("shape_sat_duty", d, 255); checkOutput("shape_sat_err", e, 0);
      shape(-2048, 0, d, e); checkOutput("shape_800_duty", d, 0);
      shape(8, 0, d, e);     checkOutput("shape_008a_duty", d, 128); checkOutput("shape_008a_err", e, 8);
      shape(8, 8, d, e);     checkOutput("shape_008b_duty", d, 129); checkOutput("shape_008b_err", e, 0);

      // Reset state.
      @(negedge clk);
      checkOutput("rst_pwm", pwm_out, 0);
      checkOutput("rst_tick", period_tick, 0);
      checkOutput("rst_underrun", underrun, 0);
      checkOutput("rst_ready", sample_ready, 1);
      #2;
      rst_n = 1'b1;
      ena   = 1'b1;

      // 1: midscale with no samples, underrun and clear behaviour.
      measure_period(highs, len);
      checkOutput("mid_highs", highs, 128);
      checkOutput("mid_len", len, 256);
      checkOutput("underrun_set", underrun, 1);
      underrun_clr = 1'b1;
      @(negedge clk);
      underrun_clr = 1'b0;
      checkOutput("underrun_clr", underrun, 0);
      wait_model_cnt(255);
      underrun_clr = 1'b1;
      @(negedge clk);
      underrun_clr = 1'b0;
      checkOutput("underrun_set_wins", underrun, 1);

      // 2: full-scale positive, then saturation; never a constant high.
      applyStimulus(12'h7FF);
      measure_period(highs, len);
      checkOutput("full_p1_highs", highs, 255);
      measure_period(highs, len);
      checkOutput("full_p2_highs", highs, 255);

      // 3: full-scale negative, then zero.
      applyStimulus(12'h800);
      measure_period(highs, len);
      checkOutput("neg_highs", highs, 0);
      applyStimulus(12'h000);
      measure_period(highs, len);
      checkOutput("zero_highs", highs, 128);

      // 4: dithering between 0x80 and 0x81.
      applyStimulus(12'h008);
      measure_period(h0, len);
      measure_period(h1, len);
      measure_period(h2, len);
      measure_period(h3, len);
      checkOutput("dither_pair1", h0 + h1, 257);
      checkOutput("dither_pair2", h2 + h3, 257);
      checkOutput("dither_alt", (h0 == 128 || h0 == 129) && (h1 != h0), 1);

      // 5: backpressure with two samples inside one period.
      underrun_clr = 1'b1;
      @(negedge clk);
      underrun_clr = 1'b0;
      applyStimulus(12'h100);
      checkOutput("bp_ready_low", sample_ready, 0);
      applyStimulus(12'h200);
      measure_period(highs, len);
      checkOutput("bp_first_highs", highs, 144);
      checkOutput("bp_no_underrun", underrun, 0);
      measure_period(highs, len);
      checkOutput("bp_second_highs", highs, 160);

      // 6a: ena dropped at cnt 50 for 100 clocks.
      wait_tick();
      highs = 0;
      len   = 0;
      while (m_cnt != 50 && len < 600) begin
         highs += int'(pwm_out); len++; @(negedge clk);
      end
      ena = 1'b0;
      repeat (100) begin
         highs += int'(pwm_out); len++; @(negedge clk);
         checkOutput("pause_pwm", pwm_out, 0);
      end
      ena = 1'b1;
      while (!period_tick && len < 1000) begin
         highs += int'(pwm_out); len++; @(negedge clk);
      end
      checkOutput("pause_len", len, 356);
      checkOutput("pause_highs", highs, 160);

      // 6b: reset mid-period with a pending sample.
      wait_model_cnt(10);
      applyStimulus(12'h7FF);
      wait_model_cnt(200);
      checkOutput("pre_rst_hold_full", sample_ready, 0);
      #2 rst_n = 1'b0;
      @(negedge clk);
      checkOutput("mid_rst_pwm", pwm_out, 0);
      checkOutput("mid_rst_tick", period_tick, 0);
      checkOutput("mid_rst_underrun", underrun, 0);
      checkOutput("mid_rst_ready", sample_ready, 1);
      #2 rst_n = 1'b1;
      measure_period(highs, len);
      checkOutput("post_rst_highs", highs, 128);
      checkOutput("post_rst_len", len, 256);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
